// File: rtl/dds_core_param_if.sv
// -----------------------------------------------------------------------------
// dds_core_param_if
//   Configuration handshake between the keypad/display front end (master)
//   and the DDS core (slave).
//   cfg_valid  master -> slave  config word present
//   cfg_ready  slave  -> master core accepts config this cycle
//   cfg_ftw    master -> slave  frequency tuning word (ACC_W bits)
//   cfg_amp    master -> slave  amplitude scale (AMP_W bits)
//   cfg_mode   master -> slave  0 sine, 1 square, 2 triangle, 3 sawtooth
// -----------------------------------------------------------------------------
interface dds_core_param_if #(
    parameter int ACC_W = 32,
    parameter int AMP_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [ACC_W-1:0] cfg_ftw;
    logic [AMP_W-1:0] cfg_amp;
    logic [1:0]       cfg_mode;

    modport master (
        output cfg_valid,
        output cfg_ftw,
        output cfg_amp,
        output cfg_mode,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ftw,
        input  cfg_amp,
        input  cfg_mode,
        output cfg_ready
    );
endinterface

// File: rtl/dds_core_param.sv
// -----------------------------------------------------------------------------
// dds_core_param
//   Phase-accumulator DDS core with four wave shapes and amplitude scaling.
//   Pipeline: S0 accumulate -> S1 ROM address -> S2 wave select (ROM data
//   arrives here) -> S3 scale. The acc value produced at edge n reaches out
//   at edge n+3. Every stage carries its own phase/mode/amp/valid so a config
//   change never produces a mixed-mode sample.
//
//   Optional feature macro: DDS_WRAP_UPDATE_EN
//     undefined : cfg_ready tied high, config loads on the handshake edge.
//     defined   : config is held in shadow registers and copied to the active
//                 set on the accumulator wrap edge (or on the next edge when
//                 the accumulator is stalled or ftw is zero), giving
//                 phase-continuous, period-aligned updates.
//
// Ports
//   clkin      in   system clock
//   rst_n      in   async reset, active low
//   enable     in   1 = accumulator advances, 0 = phase holds
//   cfg        if   config handshake (slave modport)
//   rom_addr   out  registered sine ROM address
//   rom_data   in   ROM sample, valid one cycle after rom_addr
//   out        out  scaled sample, unsigned offset-binary
//   out_valid  out  out carries a sample from an enabled phase
//   wrap       out  one-cycle pulse on accumulator carry-out
// -----------------------------------------------------------------------------
module dds_core_param #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int AMP_W  = 8
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic              enable,
    dds_core_param_if.slave   cfg,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              wrap
);

    // Only the top DATA_W+1 phase bits are needed past the accumulator:
    // the msb plus the DATA_W bits below it (triangle) or at it (sawtooth).
    localparam int PH_W   = DATA_W + 1;
    localparam int PROD_W = DATA_W + AMP_W;

    localparam logic [1:0] MODE_SINE   = 2'd0;
    localparam logic [1:0] MODE_SQUARE = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
    localparam logic [1:0] MODE_SAW    = 2'd3;

    // Active configuration
    logic [ACC_W-1:0]  ftw_r;
    logic [AMP_W-1:0]  amp_r;
    logic [1:0]        mode_r;

    // S0
    logic [ACC_W-1:0]  acc_r;
    logic [ACC_W:0]    sum_s;
    logic              carry_s;
    logic [1:0]        mode0_r;
    logic [AMP_W-1:0]  amp0_r;
    logic              v0_r;
    logic              wrap_r;

    // S1
    logic [ADDR_W-1:0] rom_addr_r;
    logic [PH_W-1:0]   ph1_r;
    logic [1:0]        mode1_r;
    logic [AMP_W-1:0]  amp1_r;
    logic              v1_r;

    // S2
    logic [PH_W-1:0]   ph2_r;
    logic [1:0]        mode2_r;
    logic [AMP_W-1:0]  amp2_r;
    logic              v2_r;
    logic [DATA_W-1:0] wave_s;
    logic [PROD_W-1:0] prod_s;

    // S3
    logic [DATA_W-1:0] out_r;
    logic              out_valid_r;

    assign sum_s   = {1'b0, acc_r} + {1'b0, ftw_r};
    assign carry_s = enable & sum_s[ACC_W];

`ifdef DDS_WRAP_UPDATE_EN
    logic [ACC_W-1:0]  sh_ftw_r;
    logic [AMP_W-1:0]  sh_amp_r;
    logic [1:0]        sh_mode_r;
    logic              pending_r;
    logic              cfg_ready_r;
    logic              copy_s;

    // A stalled or zero-rate accumulator never wraps, so copy straight away.
    assign copy_s = pending_r & (~enable | (ftw_r == '0) | sum_s[ACC_W]);

    // Shadow capture on handshake, copy to active on the wrap edge
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sh_ftw_r    <= '0;
            sh_amp_r    <= '1;
            sh_mode_r   <= 2'd0;
            pending_r   <= 1'b0;
            cfg_ready_r <= 1'b1;
            ftw_r       <= '0;
            amp_r       <= '1;
            mode_r      <= 2'd0;
        end else if (cfg.cfg_valid && cfg_ready_r) begin
            sh_ftw_r    <= cfg.cfg_ftw;
            sh_amp_r    <= cfg.cfg_amp;
            sh_mode_r   <= cfg.cfg_mode;
            pending_r   <= 1'b1;
            cfg_ready_r <= 1'b0;
        end else if (copy_s) begin
            ftw_r       <= sh_ftw_r;
            amp_r       <= sh_amp_r;
            mode_r      <= sh_mode_r;
            pending_r   <= 1'b0;
            cfg_ready_r <= 1'b1;
        end else begin
            pending_r   <= pending_r;
            cfg_ready_r <= cfg_ready_r;
        end
    end

    assign cfg.cfg_ready = cfg_ready_r;
`else
    // Direct config load; takes effect from the next accumulation
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            ftw_r  <= '0;
            amp_r  <= '1;
            mode_r <= 2'd0;
        end else if (cfg.cfg_valid) begin
            ftw_r  <= cfg.cfg_ftw;
            amp_r  <= cfg.cfg_amp;
            mode_r <= cfg.cfg_mode;
        end else begin
            ftw_r  <= ftw_r;
        end
    end

    assign cfg.cfg_ready = 1'b1;
`endif

    // S0: accumulate, flag carry, tag the new phase with the config used
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= '0;
            wrap_r  <= 1'b0;
            mode0_r <= 2'd0;
            amp0_r  <= '1;
            v0_r    <= 1'b0;
        end else begin
            if (enable) begin
                acc_r <= sum_s[ACC_W-1:0];
            end else begin
                acc_r <= acc_r;
            end
            wrap_r  <= carry_s;
            mode0_r <= mode_r;
            amp0_r  <= amp_r;
            v0_r    <= enable;
        end
    end

    // S1: present the ROM address, carry phase and tags alongside
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_r <= '0;
            ph1_r      <= '0;
            mode1_r    <= 2'd0;
            amp1_r     <= '1;
            v1_r       <= 1'b0;
        end else begin
            rom_addr_r <= acc_r[ACC_W-1 -: ADDR_W];
            ph1_r      <= acc_r[ACC_W-1 -: PH_W];
            mode1_r    <= mode0_r;
            amp1_r     <= amp0_r;
            v1_r       <= v0_r;
        end
    end

    // S2: wait for the ROM sample belonging to this phase
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            ph2_r   <= '0;
            mode2_r <= 2'd0;
            amp2_r  <= '1;
            v2_r    <= 1'b0;
        end else begin
            ph2_r   <= ph1_r;
            mode2_r <= mode1_r;
            amp2_r  <= amp1_r;
            v2_r    <= v1_r;
        end
    end

    // S2 combinational wave shape from the stage's own mode and phase
    always_comb begin
        wave_s = '0;
        case (mode2_r)
            MODE_SINE:   wave_s = rom_data;
            MODE_SQUARE: wave_s = ph2_r[PH_W-1] ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            MODE_TRI:    wave_s = ph2_r[PH_W-1] ? ~ph2_r[DATA_W-1:0] : ph2_r[DATA_W-1:0];
            MODE_SAW:    wave_s = ph2_r[PH_W-1 -: DATA_W];
            default:     wave_s = '0;
        endcase
    end

    assign prod_s = {{AMP_W{1'b0}}, wave_s} * {{DATA_W{1'b0}}, amp2_r};

    // S3: scale and register; out holds while the stage carries no valid sample
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            out_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (v2_r) begin
                out_r <= prod_s[PROD_W-1 -: DATA_W];
            end else begin
                out_r <= out_r;
            end
            out_valid_r <= v2_r;
        end
    end

    assign rom_addr  = rom_addr_r;
    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign wrap      = wrap_r;

endmodule
